// File: rtl/uart_tx_frame.sv
// uart_tx_frame: parametrised UART transmitter with valid/ready input; optional line break via UART_TX_BREAK_EN.
module uart_tx_frame #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_MODE  = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst,
`ifdef UART_TX_BREAK_EN
    input  logic              i_break,
`endif
    input  logic [DATA_W-1:0] i_tx_d,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_tx_d,
    output logic              o_busy,
    output logic              o_done
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    if (DATA_W < 5 || DATA_W > 9 || CLKS_PER_BIT < 2 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
        $fatal(1, "uart_tx_frame: illegal parameter value");
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [3:0]      bit_cnt;
    logic [DATA_W:0] sh;
    logic            brk;
    logic            par;
    logic            bit_end;
    logic            stop_end;

`ifdef UART_TX_BREAK_EN
    assign brk = i_break;
`else
    assign brk = 1'b0;
`endif

    assign par      = PARITY_MODE == 2 ? ~^i_tx_d : ^i_tx_d;
    assign bit_end  = cnt == CW'(CLKS_PER_BIT - 1);
    // the final stop-bit cycle is spent in IDLE so back-to-back frames abut with no gap
    assign stop_end = bit_cnt == 4'(STOP_BITS - 1) && cnt == CW'(CLKS_PER_BIT - 2);
    assign o_ready  = state == IDLE && !brk;
    assign o_busy   = state != IDLE || brk;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            sh      <= '0;
            o_tx_d  <= 1'b1;
            o_done  <= 1'b0;
        end else begin
            o_done <= 1'b0;
            cnt    <= cnt + 1'b1;
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    o_tx_d  <= !brk;
                    if (i_valid && o_ready) begin
                        state  <= START;
                        sh     <= {par, i_tx_d};
                        o_tx_d <= 1'b0;
                    end
                end
                START: if (bit_end) begin
                    state  <= DATA;
                    cnt    <= '0;
                    o_tx_d <= sh[0];
                    sh     <= sh >> 1;
                end
                DATA: if (bit_end) begin
                    cnt <= '0;
                    if (bit_cnt == 4'(DATA_W - 1)) begin
                        bit_cnt <= '0;
                        state   <= PARITY_MODE != 0 ? PARITY : STOP;
                        o_tx_d  <= PARITY_MODE != 0 ? sh[0] : 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        o_tx_d  <= sh[0];
                        sh      <= sh >> 1;
                    end
                end
                PARITY: if (bit_end) begin
                    state  <= STOP;
                    cnt    <= '0;
                    o_tx_d <= 1'b1;
                end
                STOP: begin
                    if (stop_end) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        o_done <= 1'b1;
                    end else if (bit_end) begin
                        cnt     <= '0;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: directed scoreboard bench over 8N1, 8E1, 8O1 and 7N2 transmitters.
module tb_uart_tx_frame;
    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [8:0] d;
    logic       val [4];
    logic       brk [4];
    logic       tx  [4];
    logic       rdy [4];
    logic       bsy [4];
    logic       dn  [4];
    int         checks = 0;
    int         failures = 0;
    bit         q[$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int DW = g == 3 ? 7 : 8;
        localparam int PM = g == 1 ? 1 : g == 2 ? 2 : 0;
        localparam int SB = g == 3 ? 2 : 1;
        uart_tx_frame #(.DATA_W(DW), .CLKS_PER_BIT(C), .PARITY_MODE(PM), .STOP_BITS(SB)) u (
            .clk(clk),
            .rst(rst),
`ifdef UART_TX_BREAK_EN
            .i_break(brk[g]),
`endif
            .i_tx_d(d[DW-1:0]),
            .i_valid(val[g]),
            .o_ready(rdy[g]),
            .o_tx_d(tx[g]),
            .o_busy(bsy[g]),
            .o_done(dn[g])
        );
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int s, input string tag);
        chk({tag, "_line"}, 32'(tx[s]), 1);
        chk({tag, "_ready"}, 32'(rdy[s]), 1);
        chk({tag, "_busy"}, 32'(bsy[s]), 0);
        chk({tag, "_done"}, 32'(dn[s]), 0);
    endtask

    // expected serial bit sequence for one frame on instance s
    task automatic push_frame(input int s, input logic [8:0] w);
        int dw = s == 3 ? 7 : 8;
        int pm = s == 1 ? 1 : s == 2 ? 2 : 0;
        bit p = 1'b0;
        q.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            q.push_back(w[i]);
            p ^= w[i];
        end
        if (pm != 0) q.push_back(pm == 2 ? !p : p);
        repeat (s == 3 ? 2 : 1) q.push_back(1'b1);
    endtask

    task automatic run_frame(input int s, input string tag, input bit hold, input int poke);
        int len = s == 0 ? 10 : s == 3 ? 10 : 11;
        int n = len * C;
        bit b[16];
        for (int i = 0; i < len; i++) b[i] = q.pop_front();
        for (int i = 0; i < n; i++) begin
            if (i == 0 && !hold) val[s] = 1'b0;
            if (i == poke) begin
                val[s] = 1'b1;
                d = ~d;
            end
            if (poke >= 0 && i == poke + 1) val[s] = 1'b0;
            chk({tag, "_line"}, 32'(tx[s]), 32'(b[i / C]));
            chk({tag, "_done"}, 32'(dn[s]), 32'(i == n - 1));
            chk({tag, "_ready"}, 32'(rdy[s]), 32'(i == n - 1 && !brk[s]));
            chk({tag, "_busy"}, 32'(bsy[s]), 32'(i != n - 1 || brk[s]));
            tick();
        end
    endtask

    initial begin
        d = '0;
        for (int s = 0; s < 4; s++) begin
            val[s] = 1'b0;
            brk[s] = 1'b0;
        end
        tick();
        tick();
        for (int s = 0; s < 4; s++) idle(s, "reset");
        rst = 1'b0;
        tick();

        d = 9'h0A5;
        val[0] = 1'b1;
        push_frame(0, d);
        tick();
        run_frame(0, "n8_a5", 1'b0, 10);
        idle(0, "n8_after");

        d = 9'h007;
        val[1] = 1'b1;
        push_frame(1, d);
        tick();
        run_frame(1, "e8_07", 1'b0, -1);
        idle(1, "e8_after");

        val[2] = 1'b1;
        push_frame(2, d);
        tick();
        run_frame(2, "o8_07", 1'b0, -1);
        idle(2, "o8_after");

        d = 9'h055;
        val[3] = 1'b1;
        push_frame(3, 9'h055);
        push_frame(3, 9'h02A);
        tick();
        d = 9'h02A;
        run_frame(3, "b2b_first", 1'b1, -1);
        run_frame(3, "b2b_second", 1'b0, -1);
        idle(3, "b2b_after");

        d = 9'h0FF;
        val[0] = 1'b1;
        tick();
        val[0] = 1'b0;
        repeat (6) tick();
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            idle(0, "rst_mid");
        end
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            idle(0, "rst_post");
        end

`ifdef UART_TX_BREAK_EN
        brk[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            chk("brk_ready", 32'(rdy[0]), 0);
            chk("brk_busy", 32'(bsy[0]), 1);
            tick();
            chk("brk_line", 32'(tx[0]), 0);
        end
        brk[0] = 1'b0;
        chk("brk_rel_ready", 32'(rdy[0]), 1);
        tick();
        chk("brk_rel_line", 32'(tx[0]), 1);

        d = 9'h03C;
        val[0] = 1'b1;
        push_frame(0, d);
        tick();
        brk[0] = 1'b1;
        run_frame(0, "brk_mid", 1'b0, -1);
        chk("brk_mid_line", 32'(tx[0]), 0);
        brk[0] = 1'b0;
        tick();
        idle(0, "brk_mid_rel");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
